// File: rtl/fifo_drain_unit.sv
// fifo_drain_unit: byte FIFO feeding a one-byte-at-a-time drain controller.
// The producer writes bytes into a circular buffer. The drain FSM pops one
// byte, presents it on out_data and pulses out_start. It then waits for the
// transmitter to report tx_done before it starts on the next byte.
//
// Handshake with the transmitter: out_start is a single-cycle pulse. While
// out_start is high, out_data already holds the byte to send, and it stays
// stable until the next byte is latched. The transmitter raises tx_done
// (one cycle is enough) when it has finished. tx_done is only looked at in
// WAIT. At any other time it is ignored.
module fifo_drain_unit #(
  parameter int DEPTH = 512,
  parameter int CNT_W = 10,
  parameter int DBG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             enable,
  input  logic             tx_done,
  output logic [7:0]       out_data,
  output logic             out_start,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             fifo_busy,
  output logic             drain_idle,
  output logic [DBG_W-1:0] dbg_state
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // State codes are visible on dbg_state, so the encoding is fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } drainState_t;

  drainState_t       state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic [7:0]        rdData;
  logic              popReq;
  logic              wrAccept;
  logic              popAccept;

  // Status is decoded from the count, not from a pointer comparison.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_count = count;
  assign fifo_busy  = busy;

  // A write is refused while full, and also for the one cycle after any
  // committed operation. An internal pop needs only a non-empty FIFO.
  assign popReq    = (state == POP);
  assign wrAccept  = wr_en && !fifo_full && !busy;
  assign popAccept = popReq && !fifo_empty;

  // Storage array. It has no reset, because a slot is only read after it
  // has been written.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr] <= wr_data;
    end
  end

  // Pointers, occupancy count, busy flag and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      busy   <= 1'b0;
      rdData <= 8'h00;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (popAccept) begin
        rdPtr  <= rdPtr + ADDR_W'(1);
        rdData <= mem[rdPtr];
      end
      // A write and a pop in the same cycle cancel each other in the count.
      case ({wrAccept, popAccept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      busy <= wrAccept || popAccept;
    end
  end

  // Drain FSM. out_data and out_start are registered. out_start is raised
  // on entry to START, so it is high for exactly the cycle spent in START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_data  <= 8'h00;
      out_start <= 1'b0;
    end else begin
      out_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fifo_empty && !busy) begin
            state <= POP;
          end
        end
        POP: begin
          state <= LATCH;
        end
        LATCH: begin
          out_data  <= rdData;
          out_start <= 1'b1;
          state     <= START;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Debug and status views of the FSM for the display driver.
  assign dbg_state  = DBG_W'(state);
  assign drain_idle = (state == IDLE) && fifo_empty;

endmodule

// File: tb/tb_fifo_drain_unit.sv
// tb_fifo_drain_unit: directed bench for fifo_drain_unit. It keeps a
// queue-based reference of the FIFO and drain sequence, an expected-byte
// scoreboard, and a transmitter responder that answers out_start with tx_done.
module tb_fifo_drain_unit;

  localparam int DEPTH = 512;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       enable;
  logic       tx_done = 1'b0;
  logic [7:0] out_data;
  logic       out_start;
  logic [9:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_busy;
  logic       drain_idle;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  fifo_drain_unit #(.DEPTH(DEPTH), .CNT_W(10), .DBG_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .enable(enable),
    .tx_done(tx_done),
    .out_data(out_data),
    .out_start(out_start),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .fifo_busy(fifo_busy),
    .drain_idle(drain_idle),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int passes = 0;
  bit checkOn = 1'b0;
  int startCount = 0;
  int txDelay = 5;
  int txTimer = 0;

  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // The model works at the level of the FIFO contents: a byte queue, a
  // one-cycle busy flag, and the drain step number (0 idle, 1 pop, 2 latch,
  // 3 start, 4 wait). Inputs are captured at the rising edge, and the model
  // advances at the following falling edge.
  logic [7:0] mq[$];
  int         mState = 0;
  bit         mBusy = 1'b0;
  logic [7:0] mRd = 8'h00;
  logic [7:0] mOut = 8'h00;

  logic       sWr = 1'b0;
  logic [7:0] sData = 8'h00;
  logic       sEn = 1'b0;
  logic       sTx = 1'b0;
  logic       sRst = 1'b0;

  always @(posedge clk) begin
    sWr   <= wr_en;
    sData <= wr_data;
    sEn   <= enable;
    sTx   <= tx_done;
    sRst  <= reset;
  end

  task automatic modelStep();
    bit wrAcc;
    bit popAcc;
    int nxt;
    wrAcc  = sWr && (mq.size() < DEPTH) && !mBusy;
    popAcc = (mState == 1) && (mq.size() > 0);
    nxt = mState;
    if (mState == 0 && sEn && mq.size() > 0 && !mBusy) nxt = 1;
    else if (mState == 1) nxt = 2;
    else if (mState == 2) begin nxt = 3; mOut = mRd; end
    else if (mState == 3) nxt = 4;
    else if (mState == 4 && sTx) nxt = 0;
    if (popAcc) mRd = mq.pop_front();
    if (wrAcc) mq.push_back(sData);
    mBusy  = wrAcc || popAcc;
    mState = nxt;
  endtask

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      mState = 0;
      mBusy  = 1'b0;
      mRd    = 8'h00;
      mOut   = 8'h00;
    end else if (sRst) begin
      modelStep();
    end
    if (checkOn && reset) begin
      check("out_data", out_data, mOut);
      check("out_start", out_start, (mState == 3));
      check("fifo_count", fifo_count, mq.size());
      check("fifo_empty", fifo_empty, (mq.size() == 0));
      check("fifo_full", fifo_full, (mq.size() == DEPTH));
      check("fifo_busy", fifo_busy, mBusy);
      check("drain_idle", drain_idle, (mState == 0 && mq.size() == 0));
      check("dbg_state", dbg_state, mState);
      if (out_start) begin
        startCount++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected_start: got 0x%0h expected no start", out_data);
        end else begin
          check("sb_byte", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- transmitter responder ----------------
  // Raises tx_done for one cycle txDelay cycles after each out_start.
  always @(negedge clk) begin
    if (!reset) begin
      txTimer = 0;
      tx_done = 1'b0;
    end else begin
      if (txTimer > 0) begin
        txTimer--;
        tx_done = (txTimer == 0);
      end else begin
        tx_done = 1'b0;
      end
      if (out_start) txTimer = txDelay;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic writeByte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    check("busy_after_write", fifo_busy, 1);
  endtask

  task automatic waitState(input logic [3:0] s, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin hit = 1'b1; break; end
    end
    check("wait_state_reached", hit, 1);
  endtask

  task automatic waitDrained(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drain_idle) begin hit = 1'b1; break; end
    end
    check("drain_finished", hit, 1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_empty"}, fifo_empty, 1);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_busy"}, fifo_busy, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_start"}, out_start, 0);
    check({tag, "_dbg"}, dbg_state, 0);
    check({tag, "_idle"}, drain_idle, 1);
  endtask

  // Safety net so the run always ends.
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bit found;
    int startsBefore;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    checkOn = 1'b1;
    #1 checkResetValues("init");
    @(negedge clk);
    #2 reset = 1'b1;

    // Two writes with drain disabled.
    writeByte(8'h41);
    writeByte(8'h42);
    @(negedge clk);
    check("two_writes_count", fifo_count, 2);
    check("two_writes_busy_clear", fifo_busy, 0);
    check("no_start_while_disabled", startCount, 0);

    // Drain both bytes. tx_done is answered 5 cycles after each start.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    enable = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_start) begin lat = i; break; end
    end
    check("first_start_latency", lat, 3);
    check("first_byte", out_data, 8'h41);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_start) begin found = 1'b1; break; end
    end
    check("second_start_seen", found, 1);
    check("second_byte", out_data, 8'h42);
    waitDrained(100);
    check("drained_count", fifo_count, 0);
    check("drained_idle", drain_idle, 1);
    enable = 1'b0;

    // wr_en held high: only the non-busy cycles store a byte.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("held_wr_count", fifo_count, 3);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h14);

    // A write lands in the same cycle as the pop, so the count is unchanged.
    enable = 1'b1;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    check("simul_count", fifo_count, 3);
    check("simul_state_latch", dbg_state, 2);
    check("simul_busy", fifo_busy, 1);
    exp_q.push_back(8'h99);

    // Drop enable during WAIT. The byte finishes and no new pop starts.
    waitState(4'd4, 50);
    enable = 1'b0;
    waitState(4'd0, 50);
    startsBefore = startCount;
    repeat (10) @(negedge clk);
    check("no_start_after_disable", startCount - startsBefore, 0);
    check("disabled_dbg_idle", dbg_state, 0);
    check("disabled_drain_idle", drain_idle, 0);
    check("disabled_count", fifo_count, 3);

    // Reset in the middle of a transfer.
    enable = 1'b1;
    waitState(4'd2, 50);
    #2 reset = 1'b0;
    exp_q.delete();
    enable = 1'b0;
    #1 checkResetValues("midrun");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Fill to capacity, overflow once, then drain everything. Pointers wrap.
    txDelay = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'(i));
      writeByte(8'(i));
    end
    check("fill_count", fifo_count, 512);
    check("fill_full", fifo_full, 1);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("overflow_count", fifo_count, 512);
    check("overflow_full", fifo_full, 1);
    check("overflow_not_busy", fifo_busy, 0);
    enable = 1'b1;
    waitDrained(6000);
    check("full_drain_count", fifo_count, 0);
    check("full_drain_empty", fifo_empty, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
